// File: rtl/reg_mem_bist_pkg.sv
// reg_mem_bist_pkg
// Shared definitions for the reg_mem built-in self-test initiator:
//   - bist_state_e   : controller state encoding
//   - RD_LAT_MIN/MAX : supported read-latency range of the attached memory
//   - rd_lat_legal() : range check on a read-latency value
//   - bist_pattern() : expected data word for a given seed and address
package reg_mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  localparam int RD_LAT_MIN = 0;
  localparam int RD_LAT_MAX = 1;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  // Incrementing pattern; callers truncate to the data width, which gives
  // the modulo-2**DATA_WIDTH wrap.
  function automatic logic [31:0] bist_pattern(input logic [31:0] seed,
                                               input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/reg_mem_bist_chk.sv
// reg_mem_bist_chk
// Read-back checker for reg_mem_bist. Delays each issued read (expected
// word + address + valid) by RD_LAT cycles so it lines up with the memory
// read data, then compares and accumulates the result.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             start of a new run: clear delay line and results
//   issue_valid_i       a read address is being presented this cycle
//   issue_addr_i        address being read
//   issue_exp_i         value that address should hold
//   mem_rdata_i         read data from the memory
//   finish_i            this edge enters DONE: latch pass from final count
//   err_count_o         number of mismatching words
//   first_err_addr_o    address of the first mismatch (0 if none)
//   pass_o              1 when the finished run had no mismatches
module reg_mem_bist_chk
  import reg_mem_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_BITS  = 3,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  issue_valid_i,
  input  logic [ADDR_BITS-1:0]  issue_addr_i,
  input  logic [DATA_WIDTH-1:0] issue_exp_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  finish_i,
  output logic [ADDR_BITS:0]    err_count_o,
  output logic [ADDR_BITS-1:0]  first_err_addr_o,
  output logic                  pass_o
);

  logic                  cmp_valid;
  logic [ADDR_BITS-1:0]  cmp_addr;
  logic [DATA_WIDTH-1:0] cmp_exp;

  generate
    if (RD_LAT == 0) begin : g_comb_read
      // Combinational-read memory: data belongs to the address shown now.
      assign cmp_valid = issue_valid_i;
      assign cmp_addr  = issue_addr_i;
      assign cmp_exp   = issue_exp_i;
    end else begin : g_delay_line
      logic                  dl_valid_q [RD_LAT];
      logic [ADDR_BITS-1:0]  dl_addr_q  [RD_LAT];
      logic [DATA_WIDTH-1:0] dl_exp_q   [RD_LAT];

      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic                  src_valid;
        logic [ADDR_BITS-1:0]  src_addr;
        logic [DATA_WIDTH-1:0] src_exp;

        if (gi == 0) begin : g_head
          assign src_valid = issue_valid_i;
          assign src_addr  = issue_addr_i;
          assign src_exp   = issue_exp_i;
        end else begin : g_tail
          assign src_valid = dl_valid_q[gi-1];
          assign src_addr  = dl_addr_q[gi-1];
          assign src_exp   = dl_exp_q[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dl_valid_q[gi] <= 1'b0;
            dl_addr_q[gi]  <= '0;
            dl_exp_q[gi]   <= '0;
          end else if (clear_i) begin
            dl_valid_q[gi] <= 1'b0;
            dl_addr_q[gi]  <= '0;
            dl_exp_q[gi]   <= '0;
          end else begin
            dl_valid_q[gi] <= src_valid;
            dl_addr_q[gi]  <= src_addr;
            dl_exp_q[gi]   <= src_exp;
          end
        end
      end

      assign cmp_valid = dl_valid_q[RD_LAT-1];
      assign cmp_addr  = dl_addr_q[RD_LAT-1];
      assign cmp_exp   = dl_exp_q[RD_LAT-1];
    end
  endgenerate

  logic                 mismatch;
  logic [ADDR_BITS:0]   err_q, err_d;
  logic [ADDR_BITS-1:0] first_q, first_d;
  logic                 seen_q, seen_d;
  logic                 pass_q, pass_d;

  // At most 2**ADDR_BITS compares per run, so the extra count bit means
  // err_d can never wrap.
  always_comb begin
    mismatch = cmp_valid && (mem_rdata_i != cmp_exp);
    err_d    = err_q + {{ADDR_BITS{1'b0}}, mismatch};
    first_d  = first_q;
    seen_d   = seen_q;
    pass_d   = pass_q;
    if (mismatch && !seen_q) begin
      first_d = cmp_addr;
      seen_d  = 1'b1;
    end
    // The final compare lands on the same edge as finish_i, so pass is
    // judged on the updated count.
    if (finish_i) begin
      pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (clear_i) begin
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign pass_o           = pass_q;

endmodule

// File: rtl/reg_mem_bist.sv
// reg_mem_bist
// Built-in self-test initiator for one reg_mem instance. On start it writes
// SEED+addr to every address, reads every address back and reports the
// number of mismatches, the first failing address and an overall pass flag.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           run request, sampled only while idle
//   mem_addr_o        address to reg_mem (0 when not writing/reading)
//   mem_wdata_o       write data to reg_mem (0 outside the write phase)
//   mem_wen_o         write enable to reg_mem
//   mem_rdata_i       read data from reg_mem
//   busy_o            run in progress (first cycle after start .. DONE)
//   done_o            one-cycle pulse when results are final
//   pass_o            no mismatches in the last run (held)
//   err_count_o       mismatch count of the last run (held)
//   first_err_addr_o  first mismatching address of the last run (held)
module reg_mem_bist
  import reg_mem_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_BITS  = 3,
  parameter int SEED       = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_wen_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_BITS:0]    err_count_o,
  output logic [ADDR_BITS-1:0]  first_err_addr_o
);

  // An unsupported latency falls back to the registered-read behaviour.
  localparam int RD_LAT_EFF = rd_lat_legal(RD_LAT) ? RD_LAT : RD_LAT_MAX;
  localparam int N          = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] IDX_LAST = ADDR_BITS'(N - 1);

  bist_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] pat_value;
  logic                 accept;
  logic                 finish;

  assign pat_value = DATA_WIDTH'(bist_pattern(32'(SEED), 32'(idx_q)));
  assign accept    = (state_q == ST_IDLE) && start_i;
  assign finish    = (state_q != ST_DONE) && (state_d == ST_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_WRITE;
          idx_d   = '0;
        end
      end
      ST_WRITE: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_READ: begin
        if (idx_q == IDX_LAST) begin
          state_d = (RD_LAT_EFF == 0) ? ST_DONE : ST_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // Latency is at most one cycle, so the drain is a single cycle.
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Memory pins and status decode only from state/index registers.
  assign mem_wen_o   = (state_q == ST_WRITE);
  assign mem_addr_o  = ((state_q == ST_WRITE) || (state_q == ST_READ)) ? idx_q : '0;
  assign mem_wdata_o = (state_q == ST_WRITE) ? pat_value : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

  reg_mem_bist_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS),
    .RD_LAT     (RD_LAT_EFF)
  ) u_chk (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear_i          (accept),
    .issue_valid_i    (state_q == ST_READ),
    .issue_addr_i     (idx_q),
    .issue_exp_i      (pat_value),
    .mem_rdata_i      (mem_rdata_i),
    .finish_i         (finish),
    .err_count_o      (err_count_o),
    .first_err_addr_o (first_err_addr_o),
    .pass_o           (pass_o)
  );

endmodule

// File: tb/tb_reg_mem_bist.sv
// tb_reg_mem_bist
// Directed bench: DUT A (SEED=10, registered read) with a fault-injecting
// memory model, DUT B (SEED=15, combinational read) with a plain model.
module tb_reg_mem_bist;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults, RD_LAT=1 ----------------
  logic       rst_n_a, start_a;
  logic [2:0] mem_addr_a, first_a;
  logic [3:0] mem_wdata_a, rdata_a, err_a;
  logic       mem_wen_a, busy_a, done_a, pass_a;
  logic [3:0] mem_a  [8];
  logic [3:0] flip_a [8];

  reg_mem_bist #(.DATA_WIDTH(4), .ADDR_BITS(3), .SEED(10), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .start_i(start_a),
    .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a), .mem_wen_o(mem_wen_a),
    .mem_rdata_i(rdata_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_count_o(err_a), .first_err_addr_o(first_a)
  );

  // Registered-read memory; flip_a corrupts read data per address.
  always @(posedge clk) begin
    if (mem_wen_a) mem_a[mem_addr_a] <= mem_wdata_a;
    rdata_a <= mem_a[mem_addr_a] ^ flip_a[mem_addr_a];
  end

  // ---------------- DUT B: SEED=15, RD_LAT=0 ----------------
  logic       rst_n_b, start_b;
  logic [2:0] mem_addr_b, first_b;
  logic [3:0] mem_wdata_b, rdata_b, err_b;
  logic       mem_wen_b, busy_b, done_b, pass_b;
  logic [3:0] mem_b [8];

  reg_mem_bist #(.DATA_WIDTH(4), .ADDR_BITS(3), .SEED(15), .RD_LAT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .start_i(start_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b), .mem_wen_o(mem_wen_b),
    .mem_rdata_i(rdata_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(err_b), .first_err_addr_o(first_b)
  );

  always @(posedge clk) begin
    if (mem_wen_b) mem_b[mem_addr_b] <= mem_wdata_b;
  end
  assign rdata_b = mem_b[mem_addr_b];

  // ---------------- bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;

  int ndone, busy_cyc, first_done_edge, last_done_edge, nwr, wdata_leak;
  int res_pass, res_err, res_first;
  int wr_addr [32];
  int wr_data [32];

  logic [3:0] exp_wr_a [8] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
  logic [3:0] exp_wr_b [8] = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives start from mask bit k in the cycle that ends at edge k (edge 0 is
  // the first sampling edge), observing outputs on each following negedge.
  // An edge number reported for done is the edge that samples it high.
  // abort_k >= 0 pulls DUT A's reset during the cycle after edge abort_k.
  task automatic run(input bit sel, input logic [39:0] mask, input int abort_k);
    ndone = 0; busy_cyc = 0; first_done_edge = -1; last_done_edge = -1;
    nwr = 0; wdata_leak = 0; res_pass = -1; res_err = -1; res_first = -1;
    for (int k = 0; k < 40; k++) begin
      if (sel) start_b = mask[k]; else start_a = mask[k];
      @(posedge clk);
      @(negedge clk);
      if (sel ? busy_b : busy_a) busy_cyc++;
      if (sel ? done_b : done_a) begin
        ndone++;
        if (first_done_edge < 0) begin
          first_done_edge = k + 1;
          res_pass  = int'(sel ? pass_b : pass_a);
          res_err   = int'(sel ? err_b : err_a);
          res_first = int'(sel ? first_b : first_a);
        end
        last_done_edge = k + 1;
      end
      if (sel ? mem_wen_b : mem_wen_a) begin
        if (nwr < 32) begin
          wr_addr[nwr] = int'(sel ? mem_addr_b : mem_addr_a);
          wr_data[nwr] = int'(sel ? mem_wdata_b : mem_wdata_a);
        end
        nwr++;
      end else if ((sel ? mem_wdata_b : mem_wdata_a) != 4'd0) begin
        wdata_leak++;
      end
      if (k == abort_k) begin
        start_a = 1'b0;
        check("pre_rst_wen", 32'(mem_wen_a), 32'd1);
        check("pre_rst_addr", 32'(mem_addr_a), 32'd3);
        rst_n_a = 1'b0;
        #1;
        check("rst_wen", 32'(mem_wen_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_wdata", 32'(mem_wdata_a), 32'd0);
        @(negedge clk);
        rst_n_a = 1'b1;
        return;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 8; i++) flip_a[i] = 4'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_pass_a", 32'(pass_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_first_a", 32'(first_a), 32'd0);
    check("rst_wen_a", 32'(mem_wen_a), 32'd0);
    check("rst_addr_a", 32'(mem_addr_a), 32'd0);
    check("rst_wdata_a", 32'(mem_wdata_a), 32'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    // Clean run
    run(1'b0, 40'h1, -1);
    check("clean_done_edge", 32'(first_done_edge), 32'd18);
    check("clean_busy", 32'(busy_cyc), 32'd18);
    check("clean_ndone", 32'(ndone), 32'd1);
    check("clean_nwr", 32'(nwr), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("clean_wr_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("clean_wr_data%0d", i), 32'(wr_data[i]), 32'(exp_wr_a[i]));
    end
    check("clean_wdata_idle", 32'(wdata_leak), 32'd0);
    check("clean_pass", 32'(res_pass), 32'd1);
    check("clean_err", 32'(res_err), 32'd0);
    check("clean_first", 32'(res_first), 32'd0);
    check("clean_pass_held", 32'(pass_a), 32'd1);

    // Bit 1 of address 5 stuck at 0: reads 13 instead of 15
    flip_a[5] = 4'b0010;
    run(1'b0, 40'h1, -1);
    check("sa5_pass", 32'(res_pass), 32'd0);
    check("sa5_err", 32'(res_err), 32'd1);
    check("sa5_first", 32'(res_first), 32'd5);
    check("sa5_err_held", 32'(err_a), 32'd1);

    // Faults at addresses 2 and 6, run twice
    flip_a[5] = 4'd0; flip_a[2] = 4'b0001; flip_a[6] = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      run(1'b0, 40'h1, -1);
      check($sformatf("two_err_run%0d", r), 32'(res_err), 32'd2);
      check($sformatf("two_first_run%0d", r), 32'(res_first), 32'd2);
      check($sformatf("two_pass_run%0d", r), 32'(res_pass), 32'd0);
    end
    flip_a[2] = 4'd0; flip_a[6] = 4'd0;

    // start held 5 cycles, re-pulsed mid-READ and during DONE: one run only
    run(1'b0, 40'h4101F, -1);
    check("hold_ndone", 32'(ndone), 32'd1);
    check("hold_busy", 32'(busy_cyc), 32'd18);
    check("hold_done_edge", 32'(first_done_edge), 32'd18);
    check("hold_pass", 32'(res_pass), 32'd1);

    // Back-to-back: start in the IDLE cycle right after DONE is accepted
    run(1'b0, 40'h80001, -1);
    check("b2b_ndone", 32'(ndone), 32'd2);
    check("b2b_busy", 32'(busy_cyc), 32'd36);
    check("b2b_last_done_edge", 32'(last_done_edge), 32'd37);

    // Reset during the 4th write, then a clean run
    run(1'b0, 40'h1, 3);
    check("post_rst_err", 32'(err_a), 32'd0);
    check("post_rst_pass", 32'(pass_a), 32'd0);
    run(1'b0, 40'h1, -1);
    check("after_rst_pass", 32'(res_pass), 32'd1);
    check("after_rst_done_edge", 32'(first_done_edge), 32'd18);

    // DUT B: combinational read, SEED=15
    run(1'b1, 40'h1, -1);
    check("lat0_done_edge", 32'(first_done_edge), 32'd17);
    check("lat0_busy", 32'(busy_cyc), 32'd17);
    check("lat0_nwr", 32'(nwr), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lat0_wr_data%0d", i), 32'(wr_data[i]), 32'(exp_wr_b[i]));
    end
    check("lat0_pass", 32'(res_pass), 32'd1);
    check("lat0_err", 32'(res_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
